// File: rtl/delay_meter.sv
// Measures edges from a stimulus change to a response on the gate under test.
// Optional statistics counters are enabled by defining DELAY_METER_STATS_EN.
module delay_meter #(
   parameter int unsigned CW      = 8,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    stim_in,
   input  logic          dut_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_latency,
   output logic          res_timeout,
   output logic          res_level,
   output logic          busy,
   output logic [15:0]   meas_count,
   output logic [15:0]   to_count
);

   typedef enum logic [1:0] {StIdle, StMeas, StDone} state_e;

   localparam logic [CW-1:0] TimeoutCw = CW'(TIMEOUT);

   state_e        state_q, state_d;
   logic [2:0]    stim_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_ref_q, level_ref_d;
   logic [CW-1:0] res_latency_q, res_latency_d;
   logic          res_timeout_q, res_timeout_d;
   logic          res_level_q, res_level_d;
   logic          res_valid_q, res_valid_d;
   logic          busy_q, busy_d;

   logic          trigger;
   logic [CW:0]   cnt_inc;

   assign trigger = (stim_in != stim_q);
   // One extra bit so cnt+1 can be compared against TIMEOUT without wrapping.
   assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      level_ref_d   = level_ref_q;
      res_latency_d = res_latency_q;
      res_timeout_d = res_timeout_q;
      res_level_d   = res_level_q;

      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d     = StMeas;
               cnt_d       = '0;
               level_ref_d = dut_out;
            end
         end
         StMeas: begin
            if (dut_out != level_ref_q) begin
               state_d       = StDone;
               res_latency_d = cnt_inc[CW-1:0];
               res_timeout_d = 1'b0;
               res_level_d   = dut_out;
            end else if (trigger) begin
               cnt_d       = '0;
               level_ref_d = dut_out;
            end else if (cnt_inc == {1'b0, TimeoutCw}) begin
               state_d       = StDone;
               res_latency_d = TimeoutCw;
               res_timeout_d = 1'b1;
               res_level_d   = level_ref_q;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         StDone: begin
            // Triggers here are dropped; stim_q still tracks stim_in.
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d      = (state_d == StMeas);
      res_valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         stim_q        <= '0;
         cnt_q         <= '0;
         level_ref_q   <= 1'b0;
         res_latency_q <= '0;
         res_timeout_q <= 1'b0;
         res_level_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         stim_q        <= stim_in;
         cnt_q         <= cnt_d;
         level_ref_q   <= level_ref_d;
         res_latency_q <= res_latency_d;
         res_timeout_q <= res_timeout_d;
         res_level_q   <= res_level_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_latency = res_latency_q;
   assign res_timeout = res_timeout_q;
   assign res_level   = res_level_q;
   assign busy        = busy_q;

`ifdef DELAY_METER_STATS_EN
   logic        done_entry;
   logic [15:0] meas_count_q, meas_count_d;
   logic [15:0] to_count_q, to_count_d;

   assign done_entry = (state_q == StMeas) && (state_d == StDone);

   always_comb begin
      meas_count_d = meas_count_q;
      to_count_d   = to_count_q;
      if (done_entry && (meas_count_q != 16'hFFFF)) begin
         meas_count_d = meas_count_q + 16'd1;
      end
      if (done_entry && res_timeout_d && (to_count_q != 16'hFFFF)) begin
         to_count_d = to_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meas_count_q <= '0;
         to_count_q   <= '0;
      end else begin
         meas_count_q <= meas_count_d;
         to_count_q   <= to_count_d;
      end
   end

   assign meas_count = meas_count_q;
   assign to_count   = to_count_q;
`else
   assign meas_count = '0;
   assign to_count   = '0;
`endif

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter (CW=8, TIMEOUT=16) with a result scoreboard.
module tb_delay_meter;

   localparam int unsigned CW      = 8;
   localparam int unsigned TIMEOUT = 16;

`ifdef DELAY_METER_STATS_EN
   localparam int ExpMeas = 4;
   localparam int ExpTo   = 1;
`else
   localparam int ExpMeas = 0;
   localparam int ExpTo   = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    stim_in;
   logic          dut_out;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_latency;
   logic          res_timeout;
   logic          res_level;
   logic          busy;
   logic [15:0]   meas_count;
   logic [15:0]   to_count;

   typedef struct packed {
      logic [CW-1:0] lat;
      logic          to;
      logic          lvl;
   } res_t;

   res_t exp_q[$];
   res_t cur;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   delay_meter #(.CW(CW), .TIMEOUT(TIMEOUT)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .stim_in     (stim_in),
      .dut_out     (dut_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_latency (res_latency),
      .res_timeout (res_timeout),
      .res_level   (res_level),
      .busy        (busy),
      .meas_count  (meas_count),
      .to_count    (to_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int lat, input logic to, input logic lvl);
      res_t r;
      r.lat = CW'(lat);
      r.to  = to;
      r.lvl = lvl;
      exp_q.push_back(r);
   endtask

   task automatic expect_result(input string tag);
      chk({tag, " valid"}, 32'(res_valid), 32'd1);
      chk({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         chk({tag, " latency"}, 32'(res_latency), 32'(cur.lat));
         chk({tag, " timeout"}, 32'(res_timeout), 32'(cur.to));
         chk({tag, " level"}, 32'(res_level), 32'(cur.lvl));
         chk({tag, " busy"}, 32'(busy), 32'd0);
      end
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      stim_in   = 3'b000;
      dut_out   = 1'b0;
      res_ready = 1'b0;
      tick();
      tick();
      chk("reset valid", 32'(res_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset latency", 32'(res_latency), 32'd0);
      chk("reset timeout", 32'(res_timeout), 32'd0);
      chk("reset level", 32'(res_level), 32'd0);
      chk("reset meas_count", 32'(meas_count), 32'd0);
      chk("reset to_count", 32'(to_count), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle busy", 32'(busy), 32'd0);

      // Normal response three edges after the trigger edge.
      stim_in = 3'b111;
      push(3, 1'b0, 1'b1);
      tick();
      chk("normal busy", 32'(busy), 32'd1);
      tick();
      tick();
      chk("normal pending", 32'(res_valid), 32'd0);
      dut_out = 1'b1;
      tick();
      expect_result("normal");
      release_result();
      chk("normal released", 32'(res_valid), 32'd0);

      // Timeout with dut_out held low.
      dut_out = 1'b0;
      tick();
      stim_in = 3'b000;
      push(TIMEOUT, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
      chk("timeout not early", 32'(res_valid), 32'd0);
      chk("timeout busy", 32'(busy), 32'd1);
      tick();
      expect_result("timeout");
      release_result();

      // Restart at cnt=2, response four edges after the second change.
      stim_in = 3'b001;
      tick();
      tick();
      tick();
      stim_in = 3'b010;
      push(4, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      tick();
      chk("restart pending", 32'(res_valid), 32'd0);
      dut_out = 1'b1;
      tick();
      expect_result("restart");

      // Backpressure: stimulus churns while the result is held.
      for (int i = 0; i < 5; i++) begin
         stim_in = stim_in + 3'd1;
         dut_out = ~dut_out;
         tick();
         chk("hold valid", 32'(res_valid), 32'd1);
         chk("hold latency", 32'(res_latency), 32'(cur.lat));
         chk("hold timeout", 32'(res_timeout), 32'(cur.to));
         chk("hold level", 32'(res_level), 32'(cur.lvl));
      end
      stim_in   = stim_in + 3'd1;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("ready edge valid", 32'(res_valid), 32'd0);
      chk("ready edge busy", 32'(busy), 32'd0);
      tick();
      chk("no new meas busy", 32'(busy), 32'd0);
      chk("no new meas valid", 32'(res_valid), 32'd0);

      // Fastest response: latency 1.
      stim_in = stim_in + 3'd1;
      tick();
      dut_out = ~dut_out;
      push(1, 1'b0, dut_out);
      tick();
      expect_result("lat1");
      release_result();
      chk("stats meas_count", 32'(meas_count), 32'(ExpMeas));
      chk("stats to_count", 32'(to_count), 32'(ExpTo));

      // Reset mid-measurement at cnt=5.
      stim_in = stim_in + 3'd1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("mid busy", 32'(busy), 32'd1);
      reset   = 1'b1;
      stim_in = 3'b101;
      tick();
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort valid", 32'(res_valid), 32'd0);
      chk("abort meas_count", 32'(meas_count), 32'd0);
      chk("abort to_count", 32'(to_count), 32'd0);
      reset = 1'b0;
      tick();
      chk("post-reset trigger busy", 32'(busy), 32'd1);
      chk("post-reset valid", 32'(res_valid), 32'd0);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
